// File: rtl/uart_xmit.sv
// UART transmitter: AXI-Stream byte in, start/data(LSB first)/parity/stop frame out on tx.
// Define UART_XMIT_TX_HOLD_EN to add a one-entry holding register for gap-free back-to-back frames.
module uart_xmit #(
  parameter int    CLK_FREQ  = 50_000_000,
  parameter int    BAUD      = 115200,
  parameter int    DATA_BITS = 8,
  parameter string PARITY    = "even",
  parameter int    STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic                 tx,
  output logic                 busy
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int CNT_W    = $clog2(BAUD_DIV) + 1;
  localparam int BIT_W    = $clog2(DATA_BITS) + 1;
  localparam bit PAR_EN   = (PARITY != "none");
  localparam bit PAR_ODD  = (PARITY == "odd");

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     baud_q;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 tready_q, tready_d;

  logic                 baud_tick;
  logic                 accept;
  logic                 stop_done;
  logic                 launch;
  logic [DATA_BITS-1:0] launch_data;

`ifdef UART_XMIT_TX_HOLD_EN
  logic                 hold_full_q, hold_full_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 launch_hold, launch_new;
`endif

  assign baud_tick = (baud_q == BAUD_LAST);
  assign accept    = s_axis_tvalid & tready_q;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d     = state_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    par_d       = par_q;
    stop_done   = 1'b0;
    launch      = 1'b0;
    launch_data = s_axis_tdata;

    unique case (state_q)
      IDLE: ;
      START: if (baud_tick) begin
        state_d = DATA;
        bit_d   = '0;
      end
      DATA: if (baud_tick) begin
        shift_d = shift_q >> 1;
        if (bit_q == DATA_LAST) begin
          state_d = PAR_EN ? PAR : STOP;
          bit_d   = '0;
        end else begin
          bit_d = bit_q + BIT_W'(1);
        end
      end
      PAR: if (baud_tick) begin
        state_d = STOP;
        bit_d   = '0;
      end
      STOP: if (baud_tick) begin
        if (bit_q == STOP_LAST) begin
          stop_done = 1'b1;
          bit_d     = '0;
        end else begin
          bit_d = bit_q + BIT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (stop_done) state_d = IDLE;

`ifdef UART_XMIT_TX_HOLD_EN
    // A held byte always wins at the end of STOP; a fresh byte then goes to hold.
    launch_hold = stop_done & hold_full_q;
    launch_new  = accept & ((state_q == IDLE) | (stop_done & ~hold_full_q));
    launch      = launch_hold | launch_new;
    launch_data = launch_hold ? hold_q : s_axis_tdata;
    hold_d      = hold_q;
    hold_full_d = hold_full_q & ~launch_hold;
    if (accept & ~launch_new) begin
      hold_d      = s_axis_tdata;
      hold_full_d = 1'b1;
    end
    tready_d = ~hold_full_d;
`else
    // tready is only ever high in IDLE, so any accept starts a frame.
    launch   = accept;
    tready_d = (state_d == IDLE) & ~launch;
`endif

    if (launch) begin
      state_d = START;
      shift_d = launch_data;
      par_d   = PAR_ODD ? ~^launch_data : ^launch_data;
    end

    busy_d = (state_d != IDLE);

    unique case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
      PAR:     tx_d = par_q;
      default: tx_d = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      tready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= (state_q == IDLE || baud_tick) ? '0 : baud_q + CNT_W'(1);
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      tready_q <= tready_d;
    end
  end

`ifdef UART_XMIT_TX_HOLD_EN
  // Reset drops any held byte along with the partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full_q <= 1'b0;
      hold_q      <= '0;
    end else begin
      hold_full_q <= hold_full_d;
      hold_q      <= hold_d;
    end
  end
`endif

  assign tx            = tx_q;
  assign busy          = busy_q;
  assign s_axis_tready = tready_q;

endmodule

// File: tb/tb_uart_xmit.sv
// Directed bench for uart_xmit: four instances (even, odd, none, 2 stop bits) at BAUD_DIV=16.
// Define UART_XMIT_TX_HOLD_EN to exercise the holding-register streaming case.
module tb_uart_xmit;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tdata = 8'h00;
  logic       tvalid = 1'b0;
  logic [1:0] sel   = 2'd0;

  logic [3:0] tvalid_v;
  logic [3:0] tx_v, busy_v, tready_v;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign tvalid_v = tvalid ? (4'b0001 << sel) : 4'b0000;

  wire tx_s    = tx_v[sel];
  wire busy_s  = busy_v[sel];
  wire tready_s = tready_v[sel];

  uart_xmit #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(8), .PARITY("even"), .STOP_BITS(1)) u_even (
    .clk(clk), .rst_n(rst_n), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid_v[0]),
    .s_axis_tready(tready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]));

  uart_xmit #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(8), .PARITY("odd"), .STOP_BITS(1)) u_odd (
    .clk(clk), .rst_n(rst_n), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid_v[1]),
    .s_axis_tready(tready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]));

  uart_xmit #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(8), .PARITY("none"), .STOP_BITS(1)) u_none (
    .clk(clk), .rst_n(rst_n), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid_v[2]),
    .s_axis_tready(tready_v[2]), .tx(tx_v[2]), .busy(busy_v[2]));

  uart_xmit #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(8), .PARITY("even"), .STOP_BITS(2)) u_stop2 (
    .clk(clk), .rst_n(rst_n), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid_v[3]),
    .s_axis_tready(tready_v[3]), .tx(tx_v[3]), .busy(busy_v[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Offer a byte and return #1 after the accepting edge; tvalid is left high.
  task automatic push(input logic [7:0] d);
    int n = 0;
    tdata  = d;
    tvalid = 1'b1;
    while (tready_s !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (tready_s !== 1'b1) begin
      check("push_timeout", {31'd0, tready_s}, 32'd1);
      tvalid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] d);
    push(d);
    tvalid = 1'b0;
  endtask

  // Called #1 after the accepting edge T. With pre=1 it first samples the cycle after T (tx still high),
  // then samples 16 cycles per frame bit; busy/tready are counted over every sample taken.
  task automatic check_frame(input logic [15:0] bits, input int nbits, input bit pre,
                             output int bad, output int busy_n, output int rdy_n);
    bad = 0; busy_n = 0; rdy_n = 0;
    if (pre) begin
      @(negedge clk);
      if (tx_s !== 1'b1) bad++;
      if (busy_s === 1'b1) busy_n++;
      if (tready_s === 1'b1) rdy_n++;
    end
    for (int i = 0; i < nbits; i++) begin
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        if (tx_s !== bits[i]) bad++;
        if (busy_s === 1'b1) busy_n++;
        if (tready_s === 1'b1) rdy_n++;
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int bad, bn, rn;
    int bad2, bn2, rn2;
    int bad3, bn3, rn3;
    int w;

    // Reset values and tready rising one clock after release
    repeat (3) @(negedge clk);
    check("rst_tx", {28'd0, tx_v}, 32'hF);
    check("rst_busy", {28'd0, busy_v}, 32'h0);
    check("rst_tready", {28'd0, tready_v}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("tready_after_rst", {28'd0, tready_v}, 32'hF);

    // 0xA5 even parity: 0 | 10100101 LSB first | 0 | 1
    sel = 2'd0;
    send(8'hA5);
    check_frame({1'b1, 1'b0, 8'hA5, 1'b0}, 11, 1'b1, bad, bn, rn);
    check("a5_even_tx", bad, 0);
    check("a5_even_busy", bn, 176);
`ifndef UART_XMIT_TX_HOLD_EN
    check("a5_even_tready", rn, 1);
`endif

    // 0x07 odd parity -> parity bit 0
    sel = 2'd1;
    send(8'h07);
    check_frame({1'b1, 1'b0, 8'h07, 1'b0}, 11, 1'b1, bad, bn, rn);
    check("07_odd_tx", bad, 0);
    check("07_odd_busy", bn, 176);

    // 0x07 even parity -> parity bit 1
    sel = 2'd0;
    send(8'h07);
    check_frame({1'b1, 1'b1, 8'h07, 1'b0}, 11, 1'b1, bad, bn, rn);
    check("07_even_tx", bad, 0);
    check("07_even_busy", bn, 176);

    // No parity slot: 160-clock frame
    sel = 2'd2;
    send(8'hA5);
    check_frame({1'b1, 8'hA5, 1'b0}, 10, 1'b1, bad, bn, rn);
    check("none_tx", bad, 0);
    check("none_busy", bn, 160);

    // Two stop bits: 32 clocks of high stop, tready only after them
    sel = 2'd3;
    send(8'hFF);
    check_frame({1'b1, 1'b1, 1'b0, 8'hFF, 1'b0}, 12, 1'b1, bad, bn, rn);
    check("stop2_tx", bad, 0);
    check("stop2_busy", bn, 192);
`ifndef UART_XMIT_TX_HOLD_EN
    check("stop2_tready", rn, 1);
`endif

    sel = 2'd0;
`ifndef UART_XMIT_TX_HOLD_EN
    // Backpressure: 0x3C offered mid-frame waits for IDLE, then follows after one idle clock
    w = 0;
    send(8'hA5);
    fork
      check_frame({1'b1, 1'b0, 8'hA5, 1'b0}, 11, 1'b1, bad, bn, rn);
      begin
        repeat (50) @(negedge clk);
        tdata  = 8'h3C;
        tvalid = 1'b1;
        while (tready_s !== 1'b1 && w < 400) begin
          @(negedge clk);
          w++;
        end
        @(posedge clk);
        #1;
        tvalid = 1'b0;
      end
    join
    check("bp_first_tx", bad, 0);
    check("bp_wait_cycles", w, 127);
    check_frame({1'b1, 1'b0, 8'h3C, 1'b0}, 11, 1'b1, bad, bn, rn);
    check("bp_second_tx", bad, 0);
    check("bp_second_busy", bn, 176);
`else
    // Streaming through the holding register: three contiguous frames, busy never drops
    push(8'h11);
    fork
      begin
        push(8'h22);
        check("hold_full_tready", {31'd0, tready_s}, 32'd0);
        push(8'h33);
        tvalid = 1'b0;
      end
      begin
        check_frame({1'b1, 1'b0, 8'h11, 1'b0}, 11, 1'b1, bad, bn, rn);
        check_frame({1'b1, 1'b0, 8'h22, 1'b0}, 11, 1'b0, bad2, bn2, rn2);
        check_frame({1'b1, 1'b0, 8'h33, 1'b0}, 11, 1'b0, bad3, bn3, rn3);
      end
    join
    check("hold_11_tx", bad, 0);
    check("hold_22_tx", bad2, 0);
    check("hold_33_tx", bad3, 0);
    check("hold_11_busy", bn, 177);
    check("hold_22_busy", bn2, 176);
    check("hold_33_busy", bn3, 175);
    repeat (2) @(negedge clk);
`endif

    // Reset during data bit 3 of 0x5A, then a clean resend
    send(8'h5A);
    repeat (56) @(negedge clk);
    check("rst_mid_bit2", {31'd0, tx_s}, 32'd0);
    repeat (15) @(negedge clk);
    check("rst_mid_bit3", {31'd0, tx_s}, 32'd1);
    check("rst_mid_busy_pre", {31'd0, busy_s}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_tx", {31'd0, tx_s}, 32'd1);
    check("rst_mid_busy", {31'd0, busy_s}, 32'd0);
    check("rst_mid_tready", {31'd0, tready_s}, 32'd0);
    @(negedge clk);
    check("rst_hold_tx", {31'd0, tx_s}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_tready", {31'd0, tready_s}, 32'd1);
    send(8'h5A);
    check_frame({1'b1, 1'b0, 8'h5A, 1'b0}, 11, 1'b1, bad, bn, rn);
    check("rst_resend_tx", bad, 0);
    check("rst_resend_busy", bn, 176);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
